// File: rtl/adc_responder.sv
// ---------------------------------------------------------------------------
// adc_responder
//
// Synthesizable stand-in for an LTC2308-style serial ADC. It answers the
// CONVST/SCK/SDI/SDO link driven by the ADC master, which lets the master be
// exercised in loopback or simulation without the real converter. Sample
// values come from fabric inputs, one 12-bit word per channel.
//
// All ADC_* inputs are asynchronous to clk and are synchronized internally.
// clk must run at least 8x the ADC_SCK frequency.
//
// Parameters:
//   CONV_CYCLES  clk cycles spent in CONV before the MSB appears on ADC_SDO
//                (1..255)
//   NBITS        data bits per frame; must be 12
//
// Ports:
//   clk          oversampling clock
//   reset_n      asynchronous active-low reset
//   ch_data      eight samples, channel k at [12k+11:12k]
//   ADC_CONVST   conversion start from the master (rising edge significant)
//   ADC_SCK      serial clock from the master, idles low
//   ADC_SDI      config bits from the master, sampled on SCK rise
//   ADC_SDO      sample data to the master, MSB first, changes after SCK fall
//   cfg_word     config in effect: {S/D, O/S, S1, S0, UNI, SLP}
//   busy         high while converting or shifting
//   frame_done   one-clk pulse when a full 12-bit frame completes
//   conv_count   number of completed frames, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module adc_responder #(
   parameter int unsigned CONV_CYCLES = 4,
   parameter int unsigned NBITS       = 12
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [8*NBITS-1:0]   ch_data,
   input  logic                 ADC_CONVST,
   input  logic                 ADC_SCK,
   input  logic                 ADC_SDI,
   output logic                 ADC_SDO,
   output logic [5:0]           cfg_word,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          conv_count
);

   // Elaboration-time parameter checks.
   if (NBITS != 12) begin : g_nbits_check
      $error("adc_responder: NBITS must be 12");
   end
   if (CONV_CYCLES < 1 || CONV_CYCLES > 255) begin : g_conv_check
      $error("adc_responder: CONV_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   localparam logic [7:0] CONV_LOAD   = 8'(CONV_CYCLES);
   localparam logic [3:0] LAST_BIT    = 4'(NBITS - 1);
   localparam logic [5:0] CFG_DEFAULT = 6'b100010;   // single-ended ch0, unipolar

   // ------------------------------------------------------------------------
   // Input synchronizers. Stages [0] and [1] are the two-flop synchronizer;
   // stage [2] holds the previous synchronized value for edge detection.
   // ------------------------------------------------------------------------
   logic [2:0] convst_sync_q;
   logic [2:0] sck_sync_q;
   logic [1:0] sdi_sync_q;

   // NOTE: every register uses non-blocking assignment so all flops sample
   // the same pre-edge values; blocking here would collapse the synchronizer
   // stages into a single flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         convst_sync_q <= '0;
         sck_sync_q    <= '0;
         sdi_sync_q    <= '0;
      end else begin
         convst_sync_q <= {convst_sync_q[1:0], ADC_CONVST};
         sck_sync_q    <= {sck_sync_q[1:0], ADC_SCK};
         sdi_sync_q    <= {sdi_sync_q[0], ADC_SDI};
      end
   end

   logic convst_rise;
   logic sck_rise;
   logic sck_fall;
   logic sdi_sync;

   assign convst_rise = convst_sync_q[1] & ~convst_sync_q[2];
   assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall    = ~sck_sync_q[1] & sck_sync_q[2];
   assign sdi_sync    = sdi_sync_q[1];

   // ------------------------------------------------------------------------
   // Channel selection: chan = {S1, S0, O/S} out of {S/D, O/S, S1, S0, UNI, SLP}.
   // ------------------------------------------------------------------------
   logic [NBITS-1:0] ch_arr [8];
   logic [2:0]       chan;
   logic [5:0]       cfg_q;

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         ch_arr[k] = ch_data[k*NBITS +: NBITS];
      end
   end

   assign chan = {cfg_q[3], cfg_q[2], cfg_q[4]};

   // ------------------------------------------------------------------------
   // Protocol FSM with registered outputs.
   // ------------------------------------------------------------------------
   state_t           state_q;
   logic [NBITS-1:0] shreg_q;
   logic [7:0]       timer_q;
   logic [3:0]       bitcnt_q;
   logic [2:0]       cfgcnt_q;
   logic [5:0]       cfg_shift_q;
   logic             sdo_q;
   logic             frame_done_q;
   logic [15:0]      conv_count_q;

   // NOTE: the asynchronous reset returns every output to its idle value the
   // moment reset_n falls, even mid-frame, without waiting for a clk edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         timer_q      <= '0;
         bitcnt_q     <= '0;
         cfgcnt_q     <= '0;
         cfg_shift_q  <= '0;
         cfg_q        <= CFG_DEFAULT;
         sdo_q        <= 1'b0;
         frame_done_q <= 1'b0;
         conv_count_q <= '0;
      end else begin
         frame_done_q <= 1'b0;

         // A CONVST rise restarts the conversion from any state; it also
         // takes priority over an SCK rise detected in the same cycle.
         if (convst_rise) begin
            shreg_q <= ch_arr[chan];
            timer_q <= CONV_LOAD;
            sdo_q   <= 1'b0;
            state_q <= ST_CONV;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  sdo_q <= 1'b0;
               end

               ST_CONV: begin
                  sdo_q <= 1'b0;
                  if (timer_q <= 8'd1) begin
                     sdo_q    <= shreg_q[NBITS-1];
                     bitcnt_q <= '0;
                     cfgcnt_q <= '0;
                     state_q  <= ST_SHIFT;
                  end else begin
                     timer_q <= timer_q - 8'd1;
                  end
               end

               ST_SHIFT: begin
                  if (sck_rise) begin
                     // Only the first six SDI bits of a frame form the config.
                     if (cfgcnt_q < 3'd6) begin
                        cfg_shift_q <= {cfg_shift_q[4:0], sdi_sync};
                        cfgcnt_q    <= cfgcnt_q + 3'd1;
                     end
                  end else if (sck_fall) begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                     shreg_q  <= {shreg_q[NBITS-2:0], 1'b0};
                     if (bitcnt_q == LAST_BIT) begin
                        sdo_q        <= 1'b0;
                        frame_done_q <= 1'b1;
                        conv_count_q <= conv_count_q + 16'd1;
                        state_q      <= ST_IDLE;
                        // A partial config is dropped; it only ever takes
                        // effect at the next CONVST.
                        if (cfgcnt_q == 3'd6) begin
                           cfg_q <= cfg_shift_q;
                        end
                     end else begin
                        sdo_q <= shreg_q[NBITS-2];
                     end
                  end
               end

               default: begin
                  sdo_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign ADC_SDO    = sdo_q;
   assign cfg_word   = cfg_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;
   assign conv_count = conv_count_q;

endmodule

// File: tb/tb_adc_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_responder
//
// Directed bench for adc_responder. Plays the ADC master: pulses CONVST,
// drives SCK at clk/16 with config bits on SDI and reads SDO on each SCK
// rise. A table of normal frames walks the channel mapping; hand-written
// sequences cover abort, short config, over-long frames, mid-frame reset,
// counter wrap and ch_data changes during a frame.
// ---------------------------------------------------------------------------
module tb_adc_responder;

   logic        clk;
   logic        reset_n;
   logic [95:0] ch_data;
   logic        ADC_CONVST;
   logic        ADC_SCK;
   logic        ADC_SDI;
   logic        ADC_SDO;
   logic [5:0]  cfg_word;
   logic        busy;
   logic        frame_done;
   logic [15:0] conv_count;

   logic [11:0] ch_mem [8];

   adc_responder #(
      .CONV_CYCLES (4),
      .NBITS       (12)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ch_data    (ch_data),
      .ADC_CONVST (ADC_CONVST),
      .ADC_SCK    (ADC_SCK),
      .ADC_SDI    (ADC_SDI),
      .ADC_SDO    (ADC_SDO),
      .cfg_word   (cfg_word),
      .busy       (busy),
      .frame_done (frame_done),
      .conv_count (conv_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         ch_data[k*12 +: 12] = ch_mem[k];
      end
   end

   // Count clk cycles with frame_done high.
   int fd_cnt = 0;
   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_convst();
      @(negedge clk);
      ADC_CONVST = 1'b1;
      repeat (4) @(negedge clk);
      ADC_CONVST = 1'b0;
   endtask

   // One SCK period: SDI set at the start of the low phase, SDO read at the
   // moment SCK rises.
   task automatic sck_cycle(input logic sdi_bit, output logic sdo_bit);
      ADC_SDI = sdi_bit;
      repeat (8) @(negedge clk);
      ADC_SCK = 1'b1;
      sdo_bit = ADC_SDO;
      repeat (8) @(negedge clk);
      ADC_SCK = 1'b0;
   endtask

   // Shift phase of a frame (CONVST already issued). Bits beyond the 12th are
   // OR-ed into extra.
   task automatic shift_frame(input logic [5:0] cfg, input int n_sck,
                              output logic [11:0] data, output logic extra);
      logic b;
      data  = '0;
      extra = 1'b0;
      repeat (12) @(negedge clk);
      for (int i = 0; i < n_sck; i++) begin
         sck_cycle((i < 6) ? cfg[5-i] : 1'b0, b);
         if (i < 12) data[11-i] = b;
         else        extra = extra | b;
      end
      repeat (8) @(negedge clk);
   endtask

   typedef struct {
      logic [5:0]  cfg_send;   // config shifted in during this frame
      logic [11:0] exp_data;   // sample selected by the config in effect
      logic [5:0]  exp_cfg;    // cfg_word after the frame
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [11:0] data;
      logic        extra;
      logic        b;
      int          fd0;

      ch_mem[0] = 12'hABC; ch_mem[1] = 12'h123; ch_mem[2] = 12'h456; ch_mem[3] = 12'h789;
      ch_mem[4] = 12'hDEF; ch_mem[5] = 12'hF0F; ch_mem[6] = 12'h5A5; ch_mem[7] = 12'h3C3;

      // chan = {S1, S0, O/S}; each row's data comes from the previous row's config.
      vecs[0] = '{6'b110010, 12'hABC, 6'b110010};  // default cfg -> ch0
      vecs[1] = '{6'b101110, 12'h123, 6'b101110};  // 110010 -> ch1
      vecs[2] = '{6'b111110, 12'h5A5, 6'b111110};  // 101110 -> ch6
      vecs[3] = '{6'b100110, 12'h3C3, 6'b100110};  // 111110 -> ch7
      vecs[4] = '{6'b110110, 12'h456, 6'b110110};  // 100110 -> ch2
      vecs[5] = '{6'b100010, 12'h789, 6'b100010};  // 110110 -> ch3

      reset_n    = 1'b0;
      ADC_CONVST = 1'b0;
      ADC_SCK    = 1'b0;
      ADC_SDI    = 1'b0;
      repeat (4) @(negedge clk);

      // Reset state.
      check("reset_sdo",        ADC_SDO,    1'b0);
      check("reset_cfg",        cfg_word,   6'b100010);
      check("reset_busy",       busy,       1'b0);
      check("reset_frame_done", frame_done, 1'b0);
      check("reset_count",      conv_count, 16'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // Normal frames.
      for (int v = 0; v < 6; v++) begin
         fd0 = fd_cnt;
         pulse_convst();
         shift_frame(vecs[v].cfg_send, 12, data, extra);
         check($sformatf("tbl%0d_data", v),  data,           vecs[v].exp_data);
         check($sformatf("tbl%0d_done", v),  fd_cnt - fd0,   1);
         check($sformatf("tbl%0d_cfg", v),   cfg_word,       vecs[v].exp_cfg);
         check($sformatf("tbl%0d_count", v), conv_count,     16'(v + 1));
      end

      // Abort: CONVST again after 5 SCK falls with a partial config.
      fd0 = fd_cnt;
      pulse_convst();
      repeat (12) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         logic [5:0] partial;
         partial = 6'b110010;
         sck_cycle(partial[5-i], b);
      end
      ch_mem[0] = 12'h9E1;
      pulse_convst();
      repeat (8) @(negedge clk);
      check("abort_no_done", fd_cnt - fd0, 0);
      check("abort_count",   conv_count,   16'd6);
      check("abort_cfg",     cfg_word,     6'b100010);
      check("abort_busy",    busy,         1'b1);
      shift_frame(6'b100010, 12, data, extra);
      check("abort_relatched_data", data,         12'h9E1);
      check("abort_next_count",     conv_count,   16'd7);
      check("abort_next_done",      fd_cnt - fd0, 1);

      // Short config (4 SCK) then CONVST; then a 15-SCK frame.
      pulse_convst();
      repeat (12) @(negedge clk);
      for (int i = 0; i < 4; i++) sck_cycle(1'b1, b);
      pulse_convst();
      repeat (8) @(negedge clk);
      check("short_cfg_kept", cfg_word, 6'b100010);
      fd0 = fd_cnt;
      shift_frame(6'b110010, 15, data, extra);
      check("long_data",  data,         12'h9E1);
      check("long_extra", extra,        1'b0);
      check("long_count", conv_count,   16'd8);
      check("long_done",  fd_cnt - fd0, 1);
      check("long_cfg",   cfg_word,     6'b110010);
      check("long_idle",  busy,         1'b0);

      // Reset during SHIFT bit 7 (cfg now selects ch1).
      ch_mem[1] = 12'hFFF;
      pulse_convst();
      repeat (12) @(negedge clk);
      for (int i = 0; i < 7; i++) sck_cycle(1'b0, b);
      repeat (8) @(negedge clk);
      ADC_SCK = 1'b1;
      repeat (4) @(negedge clk);
      check("pre_reset_busy", busy,    1'b1);
      check("pre_reset_sdo",  ADC_SDO, 1'b1);
      #3;
      reset_n = 1'b0;
      #1;
      check("midrst_sdo",   ADC_SDO,    1'b0);
      check("midrst_busy",  busy,       1'b0);
      check("midrst_cfg",   cfg_word,   6'b100010);
      check("midrst_count", conv_count, 16'd0);
      ADC_SCK = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      pulse_convst();
      shift_frame(6'b100010, 12, data, extra);
      check("postrst_data",  data,       12'h9E1);
      check("postrst_count", conv_count, 16'd1);

      // Counter wrap, with ch_data changed mid-shift.
      force dut.conv_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.conv_count_q;
      @(negedge clk);
      check("preload_count", conv_count, 16'hFFFF);
      fd0 = fd_cnt;
      pulse_convst();
      repeat (12) @(negedge clk);
      data = '0;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) ch_mem[0] = 12'h000;
         sck_cycle((i < 6) ? 1'b0 : 1'b0, b);
         data[11-i] = b;
      end
      repeat (8) @(negedge clk);
      check("wrap_data",  data,         12'h9E1);
      check("wrap_count", conv_count,   16'd0);
      check("wrap_done",  fd_cnt - fd0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
